valid_ready_skid_fifo: RTL and testbench
========================================

# valid_ready_skid_fifo

Parameterised elastic buffer inserted on a valid/ready link between a `valid_ready_master` and a `valid_ready_slave`. It sits directly downstream of the master and upstream of the slave. It accepts beats from the master, buffers up to `DEPTH` of them, and re-presents them to the slave in order. This absorbs slave back-pressure and breaks the combinational ready path between the two.

## Interface
- `DATA_W`, default 8: beat width in bits.
- `DEPTH`, default 4: buffer entries; a power of two, ≥ 2.
- `CNT_W`, default `$clog2(DEPTH)+1`: occupancy width (localparam, not overridable).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_s_data`  in  DATA_W  upstream beat (from master `o_m_data`).
- `i_s_valid`  in  1  upstream valid.
- `o_s_ready`  out  1  buffer can accept a beat (to master `i_m_ready`).
- `o_m_data`  out  DATA_W  downstream beat (to slave `i_s_data`).
- `o_m_valid`  out  1  downstream valid.
- `i_m_ready`  in  1  downstream ready (from slave `o_s_ready`).
- `i_flush`  in  1  synchronous discard of all buffered beats.
- `o_count`  out  CNT_W  beats currently held, 0..DEPTH.

## Operation
- **Reset values:** while `rst` is high, `o_s_ready`=0, `o_m_valid`=0, `o_count`=0, `o_m_data`=0. Pointers are cleared. The first cycle after `rst` falls has `o_s_ready`=1.
- **Push:** occurs when `i_s_valid && o_s_ready`. The beat is written at `wr_ptr` and `wr_ptr` increments modulo DEPTH.
- **Pop:** occurs when `o_m_valid && i_m_ready`. `rd_ptr` increments modulo DEPTH.
- **Ready:** `o_s_ready = !rst && (o_count != DEPTH)`. It is a function of registered state only; there is no path from `i_m_ready`.
- **Valid/data:** `o_m_valid = (o_count != 0)` and `o_m_data = mem[rd_ptr]`.
- **Occupancy:** `o_count` is +1 on push only, −1 on pop only, and unchanged on simultaneous push+pop or when idle. It never exceeds DEPTH and never underflows.
- **Full:** at full, `o_s_ready`=0. A pop in the same cycle does not allow a push that cycle, and `o_s_ready` returns high the next cycle.
- **Empty:** at empty, `o_m_valid`=0. A push becomes visible on `o_m_valid` the next cycle.
- **Pointer wrap:** pointers wrap naturally at DEPTH, and ordering is preserved across the wrap.
- **Hold:** while `o_m_valid`=1 and `i_m_ready`=0, `o_m_data` is held stable.
- **Flush:** `i_flush`=1 takes priority over push and pop in that cycle. Next cycle `o_count`=0, `o_m_valid`=0, and pointers are 0. A beat offered during the flush cycle is dropped, but `o_s_ready` still follows the full rule.
- **Reset priority:** `rst` overrides `i_flush`, push and pop. Reset mid-transfer discards all content, and no partial beat is emitted.

## Timing
- Without bypass, latency from push edge N is that `o_m_valid` is high in cycle N+1.
- Sustained throughput is 1 beat/cycle when `i_m_ready`=1 continuously and occupancy is ≥1.
- `o_s_ready` deasserts in the cycle after the push that fills entry DEPTH.
- `o_s_ready` reasserts in the cycle after the first pop from full.
- No combinational path exists from `i_m_ready` to `o_s_ready`, or from `i_s_valid` to `o_m_valid`, unless bypass is compiled in.

## Configuration
- Macro: `SKID_FIFO_BYPASS_EN`.
- **Defined:** when `o_count`==0 and `i_flush`=0, `o_m_valid = i_s_valid` and `o_m_data = i_s_data` combinationally.
  - If `i_m_ready`=1 in that cycle, the beat passes through with zero latency and is not stored, so `o_count` stays 0.
  - If `i_m_ready`=0, the beat is stored as a normal push.
  - Behaviour with `o_count`>0 is unchanged.
- **Undefined:** the buffer is fully registered, with 1-cycle minimum latency as specified above.

## Test plan
- **Reset then idle:** assert `rst` for 2 cycles with `i_s_valid`=1 → `o_s_ready`=0, `o_m_valid`=0, `o_count`=0 throughout; `o_s_ready`=1 in the first cycle after release.
- **Streaming:** push 0x01..0x10 back-to-back with `i_m_ready`=1 → `o_m_data` emits 0x01..0x10 in order, one per cycle, first beat 1 cycle after its push (0 with bypass); `o_count` ≤1.
- **Fill/stall:** hold `i_m_ready`=0 and push 0xA0..0xA5 with DEPTH=4 → 0xA0..0xA3 accepted, `o_count`=4, `o_s_ready`=0, `o_m_data`=0xA0 stable. Then pulse `i_m_ready` for 1 cycle → 0xA0 popped and 0xA4 accepted the following cycle.
- **Wrap:** run 3×DEPTH beats with random `i_m_ready` (50%) and random `i_s_valid` → scoreboard matches exact order, with no loss and no duplicates.
- **Flush:** with `o_count`=3, assert `i_flush` with `i_s_valid`=1 and data 0x55 → next cycle `o_count`=0, `o_m_valid`=0; 0x55 is never emitted.
- **Bypass build:** with `SKID_FIFO_BYPASS_EN` defined, empty buffer, `i_s_valid`=1, data 0x3C, `i_m_ready`=1 → `o_m_valid`=1 and `o_m_data`=0x3C in the same cycle, `o_count` stays 0.

Source files
------------

// File: rtl/valid_ready_skid_fifo.sv
// valid_ready_skid_fifo: DEPTH-entry elastic buffer on a valid/ready link.
// Define SKID_FIFO_BYPASS_EN for zero-latency pass-through when empty.
module valid_ready_skid_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] i_s_data,
   input  logic              i_s_valid,
   output logic              o_s_ready,
   output logic [DATA_W-1:0] o_m_data,
   output logic              o_m_valid,
   input  logic              i_m_ready,
   input  logic              i_flush,
   output logic [CNT_W-1:0]  o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic byp_sel;
   logic pass;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // Handshake decode: push/pop qualifiers and optional empty bypass.
   always_comb begin
      byp_sel   = 1'b0;
      pass      = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      o_s_ready = 1'b0;
      o_m_valid = 1'b0;
      o_m_data  = '0;
      o_count   = '0;

`ifdef SKID_FIFO_BYPASS_EN
      byp_sel = !rst && empty && !i_flush;
      pass    = byp_sel && i_s_valid && i_m_ready;
`endif

      o_s_ready = !rst && !full;
      push      = i_s_valid && o_s_ready && !i_flush && !pass;
      pop       = !rst && !empty && i_m_ready && !i_flush;

      if (!rst) begin
         o_count = count;
         if (byp_sel) begin
            o_m_valid = i_s_valid;
            o_m_data  = i_s_data;
         end else begin
            o_m_valid = !empty;
            o_m_data  = mem[rd_ptr];
         end
      end
   end

   // Storage array: written on accepted push, cleared on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= i_s_data;
      end
   end

   // Pointers and occupancy; reset and flush both empty the buffer.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_valid_ready_skid_fifo.sv
// tb_valid_ready_skid_fifo: directed stimulus with a queue scoreboard.
// Driver pushes expected beats; a negedge monitor checks and pops them.
module tb_valid_ready_skid_fifo;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              clk;
   logic              rst;
   logic [DATA_W-1:0] i_s_data;
   logic              i_s_valid;
   logic              o_s_ready;
   logic [DATA_W-1:0] o_m_data;
   logic              o_m_valid;
   logic              i_m_ready;
   logic              i_flush;
   logic [CNT_W-1:0]  o_count;

   int n_vec = 0;
   int n_err = 0;
   int count_m = 0;
   logic [DATA_W-1:0] q[$];

   valid_ready_skid_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_s_data (i_s_data),
      .i_s_valid(i_s_valid),
      .o_s_ready(o_s_ready),
      .o_m_data (o_m_data),
      .o_m_valid(o_m_valid),
      .i_m_ready(i_m_ready),
      .i_flush  (i_flush),
      .o_count  (o_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // Drive one cycle of inputs; record the beat if the model accepts it.
   task automatic step(input logic r, input logic v, input logic [7:0] d,
                       input logic mr, input logic f);
      @(posedge clk);
      #1;
      rst       = r;
      i_s_valid = v;
      i_s_data  = d;
      i_m_ready = mr;
      i_flush   = f;
      if (!r && !f && v && (count_m != DEPTH)) begin
         q.push_back(d);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && q.size() != 0; k++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      end
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_left", q.size(), 0);
   endtask

   // Monitor: compare outputs with the model, pop on each handshake.
   always @(negedge clk) begin
      logic er;
      logic ev;
      logic pu;
      logic po;
      if (rst) begin
         chk("rst_ready", o_s_ready, 0);
         chk("rst_valid", o_m_valid, 0);
         chk("rst_count", o_count, 0);
         chk("rst_data", o_m_data, 0);
         count_m = 0;
         q.delete();
      end else begin
         er = (count_m != DEPTH);
         ev = (count_m != 0);
`ifdef SKID_FIFO_BYPASS_EN
         if (count_m == 0 && !i_flush && i_s_valid) ev = 1'b1;
`endif
         chk("ready", o_s_ready, er);
         chk("valid", o_m_valid, ev);
         chk("count", o_count, count_m);
         if (ev) begin
            if (q.size() == 0) begin
               chk("sb_empty", 1, 0);
            end else begin
               chk("data", o_m_data, q[0]);
            end
         end
         if (i_flush) begin
            count_m = 0;
            q.delete();
         end else begin
            pu = i_s_valid && er;
            po = ev && i_m_ready;
            if (po && q.size() != 0) void'(q.pop_front());
            count_m = count_m + int'(pu) - int'(po);
         end
      end
   end

   initial begin
      logic [47:0] vpat;
      logic [47:0] rpat;
      rst       = 1'b1;
      i_s_valid = 1'b1;
      i_s_data  = 8'h77;
      i_m_ready = 1'b0;
      i_flush   = 1'b0;
      vpat      = 48'hB7D9_6EF3_5AC1;
      rpat      = 48'h5A3C_96E1_D24B;

      step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 1'b1, 8'(i), 1'b1, 1'b0);
      end
      drain();

      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      end
      step(1'b0, 1'b1, 8'hA4, 1'b1, 1'b0);
      step(1'b0, 1'b1, 8'hA4, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      drain();

      for (int i = 0; i < 48; i++) begin
         step(1'b0, vpat[i], 8'hC0 + 8'(i), rpat[i], 1'b0);
      end
      drain();

      step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 1'b1, 8'h66, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h67, 1'b1, 1'b0);
      drain();

      step(1'b0, 1'b1, 8'h81, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h82, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'h83, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

      step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      drain();

      @(posedge clk);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
